ps2_rx: RTL and testbench
=========================

// Module: ps2_rx
// PURPOSE
//  PS/2 device-to-host receiver; stage directly upstream of the scan-code-to-ASCII decoder.
//  Synchronises and de-glitches raw ps2_clk/ps2_data pins, deserialises 11-bit frames, checks framing.
//  Presents each good byte on scan_code with a one-cycle scan_ready pulse.
//  Host-to-device transmit is out of scope; pins are input-only here.
// PARAMETERS
//  FILTER_LEN      8     consecutive identical ps2_clk samples needed to change the filtered level (>=2)
//  TIMEOUT_CYCLES  5000  clk cycles without a falling edge mid-frame before abort (200 us @ 25 MHz)
// PORTS
//  clk        in   1  system clock; only clock in the block
//  reset      in   1  synchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock pin, asynchronous
//  ps2_data   in   1  raw PS/2 data pin, asynchronous
//  scan_code  out  8  last good byte received; held until the next good frame
//  scan_ready out  1  one-cycle pulse, coincident with a new scan_code value
//  frame_err  out  1  one-cycle pulse on bad stop bit, bad parity (macro on) or timeout
// BEHAVIOUR
//  Reset: scan_code=8'h00, scan_ready=0, frame_err=0, FSM=IDLE, bit counter=0, timeout counter=0.
//  Reset mid-frame: the partial frame is discarded and the FSM returns to IDLE with no pulses.
//  Input path: 2-FF synchroniser on both pins, then a FILTER_LEN glitch filter on the clock only.
//  fall_evt: one-cycle strobe when the filtered clock goes 1->0. Data is sampled as the synced level in that cycle.
//  Frame: start(0), D0..D7 LSB first, odd parity, stop(1).
//  FSM:
//   IDLE   : on fall_evt with data=0 -> DATA, bitcnt=0. On fall_evt with data=1, stay (spurious edge).
//   DATA   : on fall_evt, shift data into shreg[7] and shift right; bitcnt++. After the 8th bit -> PARITY.
//   PARITY : on fall_evt, latch parity bit -> STOP.
//   STOP   : on fall_evt, the frame is good if stop=1 and the parity is OK.
//            Good: scan_code<=shreg, scan_ready=1 on the next cycle.
//            Bad: frame_err=1 on the next cycle, scan_code unchanged.
//            Either way -> IDLE.
//  Latency: the pulse comes 1 clk after the stop-bit fall_evt. fall_evt itself lags the pin by 2+FILTER_LEN clks.
//  Timeout: the counter clears on every fall_evt and in IDLE, and increments in any other state.
//   At TIMEOUT_CYCLES-1: -> IDLE, frame_err pulse, no scan_ready.
//   If a fall_evt lands in the same cycle the counter reaches TIMEOUT_CYCLES-1, the edge wins and the frame continues.
//  scan_ready and frame_err are never high in the same cycle.
//  Pulse spacing >= one frame, so the 2-FF edge detector downstream sees every pulse.
//  F0/E0 prefixes are passed through as ordinary bytes; interpreting them is the downstream decoder's job.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: odd-parity failure -> frame_err pulse, byte dropped, scan_ready stays 0.
//  Not defined: the parity bit is consumed but ignored; only the stop bit and the timeout qualify a frame.
// STRUCTURE
//  Shared include ps2_defs.vh:
//   FSM state localparams (IDLE, DATA, PARITY, STOP, 2-bit encoding)
//   frame bit-count constant 8
//   default FILTER_LEN / TIMEOUT_CYCLES
//  Sub-module ps2_sync_filter:
//   synchroniser + FILTER_LEN filter + falling-edge strobe
//   outputs fall_evt and data_s
//  ps2_rx top: FSM, shift register, parity XOR, timeout counter, output registers.
// TESTING  (bench drives the pins at a 10 kHz-equivalent rate, >=20 clks per half period; FILTER_LEN=4)
//  1 Frame 8'h1C, parity 0, stop 1 -> scan_code=8'h1C, scan_ready high exactly 1 clk, frame_err 0.
//  2 Frames F0 (parity 1) then 1C (parity 0), back to back
//    -> two scan_ready pulses; codes 8'hF0 then 8'h1C.
//  3 Frame 1C with parity 1:
//    macro on  -> frame_err pulse, no scan_ready, scan_code keeps the prior value.
//    macro off -> scan_ready with 8'h1C.
//  4 Frame 5A (parity 1) with stop=0 -> frame_err pulse, no scan_ready.
//  5 Start + 4 data bits, then idle > TIMEOUT_CYCLES -> one frame_err pulse, FSM in IDLE.
//    A following frame 5A (parity 1) -> scan_code=8'h5A.
//  6 ps2_clk low for FILTER_LEN-1 clks while idle -> no state change, no pulses.
//    reset asserted 1 clk mid-frame -> all outputs 0.
//    The next full frame 8'h29 (parity 0) decodes correctly.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared constants for the PS/2 receiver: FSM encoding, frame size, parameter defaults, parity helper.
// Optional feature macro used by this block: PS2_PARITY_CHECK_EN.
package ps2_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam int FRAME_BITS          = 8;
    localparam int DEF_FILTER_LEN      = 8;
    localparam int DEF_TIMEOUT_CYCLES  = 5000;

    // True when the eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_sync_filter.sv
// PS/2 pin conditioning: 2-FF synchronisers on both pins, glitch filter on the clock,
// and a one-cycle strobe on each filtered clock falling edge.
module ps2_sync_filter
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall_evt,
    output logic data_s
);

    localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic          filt_prev_q, filt_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift synchronisers, count consecutive samples that disagree with the filtered level.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        filt_prev_d = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                cnt_d  = {CW{1'b0}};
            end else begin
                filt_d = filt_q;
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            filt_d = filt_q;
            cnt_d  = {CW{1'b0}};
        end
    end

    // State registers; idle bus level is high on both pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            cnt_q       <= {CW{1'b0}};
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_prev_q <= filt_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fall_evt = filt_prev_q & ~filt_q;
    assign data_s   = data_sync_q[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: frame FSM, shift register, parity/stop check, timeout, output pulses.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       frame_err
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic fall_evt_s;
    logic data_s;
    logic frame_ok_s;

    logic [1:0]    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_ready_q, scan_ready_d;
    logic          frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
    logic          par_q, par_d;
`endif

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall_evt (fall_evt_s),
        .data_s   (data_s)
    );

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok_s = data_s & odd_parity_ok(shreg_q, par_q);
`else
    assign frame_ok_s = data_s;
`endif

    // Frame FSM and timeout; a falling edge always beats an expiring timeout in the same cycle.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        scan_code_d  = scan_code_q;
        scan_ready_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        par_d        = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall_evt_s && !data_s) begin
                    state_d  = ST_DATA;
                    bitcnt_d = 3'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_evt_s) begin
                    shreg_d = {data_s, shreg_q[7:1]};
                    if (bitcnt_q == 3'(FRAME_BITS - 1)) begin
                        state_d  = ST_PARITY;
                        bitcnt_d = 3'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_evt_s) begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d   = data_s;
`endif
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_evt_s) begin
                    state_d = ST_IDLE;
                    if (frame_ok_s) begin
                        scan_code_d  = shreg_q;
                        scan_ready_d = 1'b1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = 3'd0;
            end
        endcase

        if (state_q == ST_IDLE || fall_evt_s) begin
            to_cnt_d = {TW{1'b0}};
        end else if (to_cnt_q == TO_MAX) begin
            to_cnt_d    = {TW{1'b0}};
            state_d     = ST_IDLE;
            bitcnt_d    = 3'd0;
            frame_err_d = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            to_cnt_q     <= {TW{1'b0}};
            scan_code_q  <= 8'h00;
            scan_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            to_cnt_q     <= to_cnt_d;
            scan_code_q  <= scan_code_d;
            scan_ready_q <= scan_ready_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q        <= par_d;
`endif
        end
    end

    assign scan_code  = scan_code_q;
    assign scan_ready = scan_ready_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the pins and checks decoded bytes and pulses.
// Honours PS2_PARITY_CHECK_EN for the bad-parity scenario.
module tb_ps2_rx;

    localparam int FILT    = 4;
    localparam int TIMEOUT = 5000;
    localparam int HALF    = 25;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_ready;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int rdy_pulses = 0;
    int rdy_hi     = 0;
    int err_pulses = 0;
    int err_hi     = 0;
    int both_hi    = 0;
    logic rdy_prev = 1'b0;
    logic err_prev = 1'b0;
    logic [7:0] last_code = 8'h00;
    logic [7:0] prev_code = 8'h00;

    ps2_rx #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scan_code  (scan_code),
        .scan_ready (scan_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (scan_ready && !rdy_prev) begin
            rdy_pulses++;
            prev_code = last_code;
            last_code = scan_code;
        end
        if (scan_ready) rdy_hi++;
        if (frame_err && !err_prev) err_pulses++;
        if (frame_err) err_hi++;
        if (scan_ready && frame_err) both_hi++;
        rdy_prev = scan_ready;
        err_prev = frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF / 2);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
        wait_clks(HALF - HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_clks(40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(2);
        n_checks++;
        if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h expected 00", scan_code); end
        n_checks++;
        if (scan_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", scan_ready); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_single();
        int r0, h0, e0;
        r0 = rdy_pulses; h0 = rdy_hi; e0 = err_pulses;
        send_frame(8'h1C, 1'b0, 1'b1);
        n_checks++;
        if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL single_code: got %h expected 1c", scan_code); end
        n_checks++;
        if (rdy_pulses - r0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", rdy_pulses - r0); end
        n_checks++;
        if (rdy_hi - h0 !== 1) begin n_fail++; $display("FAIL single_width: got %0d expected 1", rdy_hi - h0); end
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL single_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_back_to_back();
        int r0;
        r0 = rdy_pulses;
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        n_checks++;
        if (rdy_pulses - r0 !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", rdy_pulses - r0); end
        n_checks++;
        if (prev_code !== 8'hF0) begin n_fail++; $display("FAIL b2b_first: got %h expected f0", prev_code); end
        n_checks++;
        if (last_code !== 8'h1C) begin n_fail++; $display("FAIL b2b_second: got %h expected 1c", last_code); end
    endtask

    task automatic test_parity();
        int r0, e0;
        send_frame(8'h5A, 1'b1, 1'b1);
        r0 = rdy_pulses; e0 = err_pulses;
        send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        n_checks++;
        if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL parity_err: got %0d expected 1", err_pulses - e0); end
        n_checks++;
        if (rdy_pulses - r0 !== 0) begin n_fail++; $display("FAIL parity_ready: got %0d expected 0", rdy_pulses - r0); end
        n_checks++;
        if (scan_code !== 8'h5A) begin n_fail++; $display("FAIL parity_code: got %h expected 5a", scan_code); end
`else
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("FAIL parity_err: got %0d expected 0", err_pulses - e0); end
        n_checks++;
        if (rdy_pulses - r0 !== 1) begin n_fail++; $display("FAIL parity_ready: got %0d expected 1", rdy_pulses - r0); end
        n_checks++;
        if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL parity_code: got %h expected 1c", scan_code); end
`endif
    endtask

    task automatic test_stop_err();
        int r0, e0, eh0;
        r0 = rdy_pulses; e0 = err_pulses; eh0 = err_hi;
        send_frame(8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL stop_err: got %0d expected 1", err_pulses - e0); end
        n_checks++;
        if (err_hi - eh0 !== 1) begin n_fail++; $display("FAIL stop_err_width: got %0d expected 1", err_hi - eh0); end
        n_checks++;
        if (rdy_pulses - r0 !== 0) begin n_fail++; $display("FAIL stop_ready: got %0d expected 0", rdy_pulses - r0); end
    endtask

    task automatic test_timeout();
        int r0, e0;
        r0 = rdy_pulses; e0 = err_pulses;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_clks(TIMEOUT + 300);
        n_checks++;
        if (err_pulses - e0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d expected 1", err_pulses - e0); end
        n_checks++;
        if (rdy_pulses - r0 !== 0) begin n_fail++; $display("FAIL timeout_ready: got %0d expected 0", rdy_pulses - r0); end
        n_checks++;
        if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL timeout_state: got %0d expected 0", dut.state_q); end
        send_frame(8'h5A, 1'b1, 1'b1);
        n_checks++;
        if (scan_code !== 8'h5A) begin n_fail++; $display("FAIL timeout_next: got %h expected 5a", scan_code); end
    endtask

    task automatic test_glitch_and_reset();
        int r0, e0;
        r0 = rdy_pulses; e0 = err_pulses;
        ps2_clk = 1'b0;
        wait_clks(FILT - 1);
        ps2_clk = 1'b1;
        wait_clks(30);
        n_checks++;
        if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL glitch_state: got %0d expected 0", dut.state_q); end
        n_checks++;
        if ((rdy_pulses - r0) + (err_pulses - e0) !== 0) begin
            n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", (rdy_pulses - r0) + (err_pulses - e0));
        end
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        n_checks++;
        if (scan_code !== 8'h00) begin n_fail++; $display("FAIL midreset_code: got %h expected 00", scan_code); end
        n_checks++;
        if (scan_ready !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++; $display("FAIL midreset_pulses: got %b%b expected 00", scan_ready, frame_err);
        end
        n_checks++;
        if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL midreset_state: got %0d expected 0", dut.state_q); end
        ps2_data = 1'b1;
        wait_clks(60);
        r0 = rdy_pulses; e0 = err_pulses;
        send_frame(8'h29, 1'b0, 1'b1);
        n_checks++;
        if (scan_code !== 8'h29) begin n_fail++; $display("FAIL after_reset_code: got %h expected 29", scan_code); end
        n_checks++;
        if (rdy_pulses - r0 !== 1 || err_pulses - e0 !== 0) begin
            n_fail++; $display("FAIL after_reset_pulses: got rdy %0d err %0d expected 1 0", rdy_pulses - r0, err_pulses - e0);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_hi !== 0) begin n_fail++; $display("FAIL exclusive: got %0d overlap cycles expected 0", both_hi); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_stop_err();
        test_timeout();
        test_glitch_and_reset();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
